// File: rtl/multi_clock_divider.sv
// Per-channel programmable clock divider. Each channel registers its divided clock and
// one-cycle rise/fall strobes, gates only at period boundaries and reloads divisors through a one-deep slot.
module multi_clock_divider #(
    parameter int num_ch_p    = 2,
    parameter int div_width_p = 8,
    parameter int reset_div_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic [num_ch_p-1:0]             en_i,
    input  logic [num_ch_p*div_width_p-1:0] div_i,
    input  logic [num_ch_p-1:0]             load_v_i,
    output logic [num_ch_p-1:0]             load_r_o,
    output logic [num_ch_p-1:0]             clk_o,
    output logic [num_ch_p-1:0]             rise_o,
    output logic [num_ch_p-1:0]             fall_o,
    output logic [num_ch_p-1:0]             active_o
);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    localparam logic [div_width_p-1:0] ONE       = div_width_p'(1);
    localparam logic [div_width_p-1:0] TWO       = div_width_p'(2);
    localparam logic [div_width_p-1:0] RESET_DIV = div_width_p'(reset_div_p);

    for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
        state_e                 state_q, state_d;
        logic [div_width_p-1:0] cnt_q, cnt_d;
        logic [div_width_p-1:0] div_q, div_d;
        logic [div_width_p-1:0] pend_q, pend_d;
        logic                   pend_full_q, pend_full_d;
        logic                   clk_q, clk_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic [div_width_p-1:0] div_in, div_m1, high_m1;
        logic                   xfer, apply;

        assign div_in  = div_i[c*div_width_p +: div_width_p];
        assign div_m1  = div_q - ONE;
        // Odd divisors put the extra cycle in the high phase.
        assign high_m1 = div_q - (div_q >> 1) - ONE;
        assign xfer    = load_v_i[c] & ~pend_full_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            div_d   = div_q;
            clk_d   = clk_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            apply   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    clk_d = 1'b0;
                    cnt_d = '0;
                    apply = pend_full_q;
                    if (pend_full_q) div_d = pend_q;
                    if (en_i[c]) begin
                        state_d = ST_RUN;
                        clk_d   = 1'b1;
                        rise_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == high_m1) begin
                        clk_d  = 1'b0;
                        fall_d = 1'b1;
                    end
                    // high_m1 < div_m1 whenever D >= 2, so these never coincide.
                    if (cnt_q == div_m1) begin
                        cnt_d = '0;
                        apply = pend_full_q;
                        if (pend_full_q) div_d = pend_q;
                        if (en_i[c]) begin
                            clk_d  = 1'b1;
                            rise_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            endcase
        end

        assign pend_full_d = xfer | (pend_full_q & ~apply);
        assign pend_d      = xfer ? ((div_in < TWO) ? TWO : div_in) : pend_q;

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                state_q     <= ST_IDLE;
                cnt_q       <= '0;
                div_q       <= RESET_DIV;
                pend_q      <= '0;
                pend_full_q <= 1'b0;
                clk_q       <= 1'b0;
                rise_q      <= 1'b0;
                fall_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                div_q       <= div_d;
                pend_q      <= pend_d;
                pend_full_q <= pend_full_d;
                clk_q       <= clk_d;
                rise_q      <= rise_d;
                fall_q      <= fall_d;
            end
        end

        assign clk_o[c]    = clk_q;
        assign rise_o[c]   = rise_q;
        assign fall_o[c]   = fall_q;
        assign active_o[c] = (state_q == ST_RUN);
        assign load_r_o[c] = ~pend_full_q;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: hand-written per-cycle waveforms for channel 0
// plus the channel 1 clock, checked one cycle at a time.
module tb_multi_clock_divider;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [1:0]  en_i;
    logic [15:0] div_i;
    logic [1:0]  load_v_i;
    logic [1:0]  load_r_o, clk_o, rise_o, fall_o, active_o;

    int n_chk  = 0;
    int n_fail = 0;

    multi_clock_divider #(.num_ch_p(2), .div_width_p(8), .reset_div_p(4)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .en_i     (en_i),
        .div_i    (div_i),
        .load_v_i (load_v_i),
        .load_r_o (load_r_o),
        .clk_o    (clk_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .active_o (active_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        en_i     = 2'b00;
        load_v_i = 2'b00;
        div_i    = 16'h0000;
        repeat (2) tick();
        reset_ni = 1'b1;
        tick();
    endtask

    // Waveform vectors read left to right in time: bit n-1 is the first cycle checked.
    task automatic check_seq(input string tag, input int n,
                             input logic [31:0] clk_e, input logic [31:0] rise_e,
                             input logic [31:0] fall_e, input logic [31:0] lr_e,
                             input logic [31:0] act_e, input logic [31:0] c1_e);
        for (int i = 0; i < n; i++) begin
            tick();
            load_v_i = 2'b00;
            chk($sformatf("%s_clk0_c%0d", tag, i), 32'(clk_o[0]), 32'(clk_e[n-1-i]));
            chk($sformatf("%s_rise0_c%0d", tag, i), 32'(rise_o[0]), 32'(rise_e[n-1-i]));
            chk($sformatf("%s_fall0_c%0d", tag, i), 32'(fall_o[0]), 32'(fall_e[n-1-i]));
            chk($sformatf("%s_ldr0_c%0d", tag, i), 32'(load_r_o[0]), 32'(lr_e[n-1-i]));
            chk($sformatf("%s_act0_c%0d", tag, i), 32'(active_o[0]), 32'(act_e[n-1-i]));
            chk($sformatf("%s_clk1_c%0d", tag, i), 32'(clk_o[1]), 32'(c1_e[n-1-i]));
        end
    endtask

    initial begin
        do_reset();

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("rst_clk_c%0d", i), 32'(clk_o), 32'h0);
            chk($sformatf("rst_rise_c%0d", i), 32'(rise_o), 32'h0);
            chk($sformatf("rst_fall_c%0d", i), 32'(fall_o), 32'h0);
            chk($sformatf("rst_act_c%0d", i), 32'(active_o), 32'h0);
            chk($sformatf("rst_ldr_c%0d", i), 32'(load_r_o), 32'h3);
        end

        // Default D=4 on channel 0, cycles 1..12
        en_i = 2'b01;
        check_seq("d4", 12, 32'b110011001100, 32'b100010001000, 32'b001000100010,
                  32'b111111111111, 32'b111111111111, 32'b000000000000);

        // Load 5 at the boundary: one more D=4 period, then 11100
        div_i = 16'h0005; load_v_i = 2'b01;
        check_seq("d5", 14, 32'b11001110011100, 32'b10001000010000, 32'b00100001000010,
                  32'b00001111111111, 32'b11111111111111, 32'b00000000000000);

        // Load 1 is clamped to 2
        div_i = 16'h0001; load_v_i = 2'b01;
        check_seq("d1", 9, 32'b111001010, 32'b100001010, 32'b000100101,
                  32'b000001111, 32'b111111111, 32'b000000000);

        // D=6 on ch0, ch1 at D=4, load 2 mid-period
        do_reset();
        div_i = 16'h0006; load_v_i = 2'b01;
        tick();
        load_v_i = 2'b00;
        chk("idle_load_pending", 32'(load_r_o), 32'h2);
        tick();
        chk("idle_load_applied", 32'(load_r_o), 32'h3);
        en_i = 2'b11;
        check_seq("d6a", 3, 32'b111, 32'b100, 32'b000, 32'b111, 32'b111, 32'b110);
        div_i = 16'h0002; load_v_i = 2'b01;
        check_seq("d6b", 9, 32'b000101010, 32'b000101010, 32'b100010101,
                  32'b000111111, 32'b111111111, 32'b011001100);

        // Gate off at cnt==1 of D=8: period completes, then idle
        do_reset();
        div_i = 16'h0008; load_v_i = 2'b01;
        tick();
        load_v_i = 2'b00;
        tick();
        en_i = 2'b01;
        check_seq("g8a", 2, 32'b11, 32'b10, 32'b00, 32'b11, 32'b11, 32'b00);
        en_i = 2'b00;
        check_seq("g8b", 14, 32'b11000000000000, 32'b00000000000000, 32'b00100000000000,
                  32'b11111111111111, 32'b11111100000000, 32'b00000000000000);
        en_i = 2'b01;
        check_seq("g8c", 1, 32'b1, 32'b1, 32'b0, 32'b1, 32'b1, 32'b0);

        // Async reset in the high phase with a pending load
        div_i = 16'h0003; load_v_i = 2'b01;
        check_seq("ar_pre", 1, 32'b1, 32'b0, 32'b0, 32'b0, 32'b1, 32'b0);
        reset_ni = 1'b0;
        en_i     = 2'b00;
        #1;
        chk("ar_clk", 32'(clk_o), 32'h0);
        chk("ar_act", 32'(active_o), 32'h0);
        chk("ar_ldr", 32'(load_r_o), 32'h3);
        tick();
        reset_ni = 1'b1;
        tick();
        chk("ar_rel_ldr", 32'(load_r_o), 32'h3);
        en_i = 2'b01;
        check_seq("ar_d4", 8, 32'b11001100, 32'b10001000, 32'b00100010,
                  32'b11111111, 32'b11111111, 32'b00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
